// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared stage flags and stage-count/latency helpers for divider_pipe
package divider_pkg;

    typedef struct packed {
        logic valid;
        logic q_neg;
        logic r_neg;
        logic zero;
    } stage_flags_t;

    function automatic int stage_count(input int n, input int k);
        return n / k;
    endfunction

    function automatic int pipe_latency(input int n, input int k);
        return stage_count(n, k) + 1;
    endfunction

endpackage

// File: rtl/divider_pipe_stage.sv
// rtl/divider_pipe_stage.sv - K restoring-division steps (MSB first) plus the stage register
module divider_pipe_stage
    import divider_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 8,
    parameter int K     = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             clr,
    input  stage_flags_t     in_flags,
    input  logic [M-1:0]     in_rem,
    input  logic [N-1:0]     in_dq,
    input  logic [M-1:0]     in_dvs,
    input  logic [TAG_W-1:0] in_tag,
    output stage_flags_t     out_flags,
    output logic [M-1:0]     out_rem,
    output logic [N-1:0]     out_dq,
    output logic [M-1:0]     out_dvs,
    output logic [TAG_W-1:0] out_tag
);

    logic [M-1:0] rem_nxt;
    logic [N-1:0] dq_nxt;
    logic [M:0]   trial;

    // dq: unconsumed dividend bits in the upper part, resolved quotient bits shifting in at the bottom
    always_comb begin
        rem_nxt = in_rem;
        dq_nxt  = in_dq;
        trial   = '0;
        for (int b = 0; b < K; b++) begin
            trial  = {rem_nxt, dq_nxt[N-1]};
            dq_nxt = {dq_nxt[N-2:0], 1'b0};
            if (trial >= {1'b0, in_dvs}) begin
                rem_nxt   = trial[M-1:0] - in_dvs;
                dq_nxt[0] = 1'b1;
            end else begin
                rem_nxt = trial[M-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_flags <= '0;
            out_rem   <= '0;
            out_dq    <= '0;
            out_dvs   <= '0;
            out_tag   <= '0;
        end else begin
            if (clr) begin
                out_flags.valid <= 1'b0;
            end else if (en) begin
                out_flags.valid <= in_flags.valid;
            end
            if (en) begin
                out_flags.q_neg <= in_flags.q_neg;
                out_flags.r_neg <= in_flags.r_neg;
                out_flags.zero  <= in_flags.zero;
                out_rem         <= rem_nxt;
                out_dq          <= dq_nxt;
                out_dvs         <= in_dvs;
                out_tag         <= in_tag;
            end
        end
    end

endmodule

// File: rtl/divider_pipe.sv
// rtl/divider_pipe.sv - pipelined signed/unsigned divider with stall handshake; DIVIDER_PIPE_FLUSH_EN adds flush
module divider_pipe
    import divider_pkg::*;
#(
    parameter int WIDTH_DIVIDEND = 16,
    parameter int WIDTH_DIVISOR  = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_W          = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
`ifdef DIVIDER_PIPE_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH_DIVIDEND-1:0] dividend,
    input  logic [WIDTH_DIVISOR-1:0]  divisor,
    input  logic                      signed_en,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH_DIVIDEND-1:0] quotient,
    output logic [WIDTH_DIVISOR-1:0]  remainder,
    output logic                      div_zero,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int N = WIDTH_DIVIDEND;
    localparam int M = WIDTH_DIVISOR;
    localparam int K = BITS_PER_STAGE;
    localparam int S = stage_count(N, K);

    generate
        if ((N % K) != 0 || M > N || M < 2) begin : g_bad_cfg
            $error("divider_pipe: WIDTH_DIVIDEND must be a multiple of BITS_PER_STAGE and 2 <= WIDTH_DIVISOR <= WIDTH_DIVIDEND");
        end
    endgenerate

    logic clr;
    logic stall;
    logic en;
    logic dd_neg;
    logic dv_neg;
    logic dv_zero;
    logic [N-1:0] dd_mag;
    logic [M-1:0] dv_mag;

    stage_flags_t     flg [0:S];
    logic [M-1:0]     rem [0:S];
    logic [N-1:0]     dq  [0:S];
    logic [M-1:0]     dvs [0:S];
    logic [TAG_W-1:0] tag [0:S];

`ifdef DIVIDER_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall & ~clr;

    assign dv_zero = (divisor == '0);
    assign dd_neg  = signed_en & dividend[N-1];
    assign dv_neg  = signed_en & divisor[M-1];
    assign dd_mag  = dd_neg ? -dividend : dividend;
    assign dv_mag  = dv_neg ? -divisor : divisor;

    // A zero divisor runs the raw dividend unsigned: every trial subtract succeeds, so the
    // quotient fills with ones and the remainder ends up holding the low dividend bits.
    assign flg[0].valid = in_valid & in_ready;
    assign flg[0].q_neg = ~dv_zero & (dd_neg ^ dv_neg);
    assign flg[0].r_neg = ~dv_zero & dd_neg;
    assign flg[0].zero  = dv_zero;
    assign rem[0]       = '0;
    assign dq[0]        = dv_zero ? dividend : dd_mag;
    assign dvs[0]       = dv_mag;
    assign tag[0]       = in_tag;

    generate
        for (genvar i = 1; i <= S; i++) begin : g_stage
            divider_pipe_stage #(
                .N     (N),
                .M     (M),
                .K     (K),
                .TAG_W (TAG_W)
            ) u_stage (
                .clk       (clk),
                .arst_n    (arst_n),
                .en        (en),
                .clr       (clr),
                .in_flags  (flg[i-1]),
                .in_rem    (rem[i-1]),
                .in_dq     (dq[i-1]),
                .in_dvs    (dvs[i-1]),
                .in_tag    (tag[i-1]),
                .out_flags (flg[i]),
                .out_rem   (rem[i]),
                .out_dq    (dq[i]),
                .out_dvs   (dvs[i]),
                .out_tag   (tag[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (clr) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= flg[S].valid;
            end
            if (en) begin
                div_zero  <= flg[S].zero;
                out_tag   <= tag[S];
                quotient  <= flg[S].zero ? '1 : (flg[S].q_neg ? -dq[S] : dq[S]);
                remainder <= flg[S].r_neg ? -rem[S] : rem[S];
            end
        end
    end

endmodule
